// File: rtl/exc_pkg.sv
// Shared definitions for the exception-tracking pipeline: MIPS-style
// exception codes, the per-stage record layout and the commit FSM states.
package exc_pkg;

    localparam int PKG_PC_W   = 32;
    localparam int PKG_CODE_W = 5;

    localparam logic [PKG_CODE_W-1:0] EXC_INT  = 5'd0;
    localparam logic [PKG_CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [PKG_CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [PKG_CODE_W-1:0] EXC_RI   = 5'd10;
    localparam logic [PKG_CODE_W-1:0] EXC_OV   = 5'd12;
    localparam logic [PKG_CODE_W-1:0] EXC_NONE = 5'd31;

    // One in-flight instruction as seen by the tracker (default widths).
    typedef struct packed {
        logic                  valid;
        logic [PKG_PC_W-1:0]   pc;
        logic                  bd;
        logic                  eret;
        logic [PKG_CODE_W-1:0] code;
    } stage_rec_t;

    typedef enum logic {
        NORM  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/exc_track_pipe_if.sv
// Bundle of the datapath-facing signals of the exception tracker.
// master = datapath/CP0 side, slave = the tracker itself.
interface exc_track_pipe_if #(
    parameter int NSTAGE = 4,
    parameter int PC_W   = 32,
    parameter int CODE_W = 5
);
    logic                     ins_valid;
    logic [PC_W-1:0]          ins_pc;
    logic                     ins_bd;
    logic                     ins_eret;
    logic [NSTAGE*CODE_W-1:0] stage_exc;
    logic [NSTAGE-1:0]        stall;
    logic                     int_req;

    logic                     exc_take;
    logic [CODE_W-1:0]        exc_code;
    logic [PC_W-1:0]          exc_epc;
    logic                     exc_bd;
    logic                     epc_we;
    logic                     eret_take;
    logic                     flush_all;
    logic                     exl;
    logic [NSTAGE-1:0]        stage_valid;

    modport master (
        output ins_valid, ins_pc, ins_bd, ins_eret, stage_exc, stall, int_req,
        input  exc_take, exc_code, exc_epc, exc_bd, epc_we, eret_take,
               flush_all, exl, stage_valid
    );

    modport slave (
        input  ins_valid, ins_pc, ins_bd, ins_eret, stage_exc, stall, int_req,
        output exc_take, exc_code, exc_epc, exc_bd, epc_we, eret_take,
               flush_all, exl, stage_valid
    );

endinterface

// File: rtl/exc_stage_reg.sv
// One tracker stage: holds valid/pc/bd/eret and the first exception code
// recorded for the instruction currently occupying this stage.
module exc_stage_reg #(
    parameter int               PC_W   = 32,
    parameter int               CODE_W = 5,
    parameter logic [CODE_W-1:0] NEXC  = 5'h1F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              hold,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_bd,
    input  logic              in_eret,
    input  logic [CODE_W-1:0] in_code,
    input  logic [CODE_W-1:0] det_code,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic              bd,
    output logic              eret,
    output logic [CODE_W-1:0] merged
);

    logic [CODE_W-1:0] code;

    // An already recorded code always wins over this stage's detector.
    assign merged = (code != NEXC) ? code : det_code;

    // Flush beats everything; a held stage still absorbs its detector code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            bd    <= 1'b0;
            eret  <= 1'b0;
            code  <= NEXC;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            bd    <= 1'b0;
            eret  <= 1'b0;
            code  <= NEXC;
        end else if (hold) begin
            code  <= merged;
        end else if (bubble) begin
            valid <= 1'b0;
            pc    <= '0;
            bd    <= 1'b0;
            eret  <= 1'b0;
            code  <= NEXC;
        end else begin
            valid <= in_valid;
            pc    <= in_pc;
            bd    <= in_bd;
            eret  <= in_eret;
            code  <= in_code;
        end
    end

endmodule

// File: rtl/exc_track_pipe.sv
// Exception-tracking pipeline: carries per-instruction exception state
// alongside the datapath and, at commit, raises precise exceptions,
// interrupts and erets, drives the one-cycle flush and tracks EXL.
module exc_track_pipe
    import exc_pkg::*;
#(
    parameter int                NSTAGE   = 4,
    parameter int                PC_W     = 32,
    parameter int                CODE_W   = 5,
    parameter logic [CODE_W-1:0] NEXC     = EXC_NONE,
    parameter logic [CODE_W-1:0] CODE_INT = EXC_INT,
    parameter int                BD_OFF   = 4
) (
    input  logic            clk,
    input  logic            reset,
    exc_track_pipe_if.slave bus
);

    localparam int              C        = NSTAGE - 1;
    localparam int              IDX_W    = $clog2(NSTAGE);
    localparam logic [PC_W-1:0] BD_OFF_V = PC_W'(BD_OFF);

    logic [NSTAGE-1:0] valid;
    logic [NSTAGE-1:0] bd;
    logic [NSTAGE-1:0] eret;
    logic [PC_W-1:0]   pc        [NSTAGE];
    logic [CODE_W-1:0] merged    [NSTAGE];
    logic [CODE_W-1:0] det       [NSTAGE];

    logic [NSTAGE-1:0] feed_valid;
    logic [NSTAGE-1:0] feed_bd;
    logic [NSTAGE-1:0] feed_eret;
    logic [NSTAGE-1:0] bubble;
    logic [PC_W-1:0]   feed_pc   [NSTAGE];
    logic [CODE_W-1:0] feed_code [NSTAGE];

    state_t            state;
    state_t            state_nxt;
    logic              exl_q;
    logic              clear_all;

    logic [IDX_W-1:0]  vidx;
    logic              any_valid;
    logic              int_fire;
    logic              sync_exc;
    logic              take;
    logic              eret_fire;
    logic [PC_W-1:0]   victim_pc;
    logic              victim_bd;

    // Stage inputs: entry takes the new instruction, later stages take the
    // previous stage (with its merged code) or a bubble if it is stalled.
    always_comb begin
        feed_valid = '0;
        feed_bd    = '0;
        feed_eret  = '0;
        bubble     = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            feed_pc[k]   = '0;
            feed_code[k] = NEXC;
            det[k]       = bus.stage_exc[k*CODE_W +: CODE_W];
        end
        feed_valid[0] = bus.ins_valid;
        feed_pc[0]    = bus.ins_pc;
        feed_bd[0]    = bus.ins_bd;
        feed_eret[0]  = bus.ins_eret;
        for (int k = 1; k < NSTAGE; k++) begin
            feed_valid[k] = valid[k-1];
            feed_pc[k]    = pc[k-1];
            feed_bd[k]    = bd[k-1];
            feed_eret[k]  = eret[k-1];
            feed_code[k]  = merged[k-1];
            bubble[k]     = bus.stall[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        exc_stage_reg #(
            .PC_W   (PC_W),
            .CODE_W (CODE_W),
            .NEXC   (NEXC)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear_all),
            .hold     (bus.stall[k]),
            .bubble   (bubble[k]),
            .in_valid (feed_valid[k]),
            .in_pc    (feed_pc[k]),
            .in_bd    (feed_bd[k]),
            .in_eret  (feed_eret[k]),
            .in_code  (feed_code[k]),
            .det_code (det[k]),
            .valid    (valid[k]),
            .pc       (pc[k]),
            .bd       (bd[k]),
            .eret     (eret[k]),
            .merged   (merged[k])
        );
    end

    // Victim selection: an interrupt picks the oldest valid instruction,
    // a sync exception only fires at commit; interrupts win.
    always_comb begin
        vidx = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (valid[k]) vidx = IDX_W'(k);
        end
        any_valid = |valid;
        int_fire  = (state == NORM) && bus.int_req && !exl_q && any_valid;
        sync_exc  = (state == NORM) && valid[C] && (merged[C] != NEXC);
        take      = int_fire || sync_exc;
        eret_fire = (state == NORM) && valid[C] && eret[C] &&
                    (merged[C] == NEXC) && !int_fire;
        victim_pc = int_fire ? pc[vidx] : pc[C];
        victim_bd = int_fire ? bd[vidx] : bd[C];
        clear_all = take || eret_fire || (state == FLUSH);
    end

    // Commit FSM register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= NORM;
        else       state <= state_nxt;
    end

    // Any committed event costs exactly one flush cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            NORM:    if (take || eret_fire) state_nxt = FLUSH;
            FLUSH:   state_nxt = NORM;
            default: state_nxt = NORM;
        endcase
    end

    // EXL is set by any taken event and cleared by a committed eret.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          exl_q <= 1'b0;
        else if (take)      exl_q <= 1'b1;
        else if (eret_fire) exl_q <= 1'b0;
    end

    assign bus.exc_take    = take;
    assign bus.exc_code    = int_fire ? CODE_INT : merged[C];
    assign bus.exc_epc     = victim_bd ? (victim_pc - BD_OFF_V) : victim_pc;
    assign bus.exc_bd      = victim_bd;
    assign bus.epc_we      = take && !exl_q;
    assign bus.eret_take   = eret_fire;
    assign bus.flush_all   = (state == FLUSH);
    assign bus.exl         = exl_q;
    assign bus.stage_valid = valid;

endmodule

// File: tb/tb_exc_track_pipe.sv
// Bench for exc_track_pipe: directed scenarios with literal expectations
// followed by random traffic compared every cycle against a queue-of-records
// model of the tracker.
module tb_exc_track_pipe;
    import exc_pkg::*;

    localparam int NS     = 4;
    localparam int PC_W   = 32;
    localparam int CODE_W = 5;
    localparam int C      = NS - 1;
    localparam logic [CODE_W-1:0]    NONE    = EXC_NONE;
    localparam logic [NS*CODE_W-1:0] ALLNONE = {NS{EXC_NONE}};

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    exc_track_pipe_if #(.NSTAGE(NS), .PC_W(PC_W), .CODE_W(CODE_W)) bus ();

    exc_track_pipe #(
        .NSTAGE   (NS),
        .PC_W     (PC_W),
        .CODE_W   (CODE_W),
        .NEXC     (EXC_NONE),
        .CODE_INT (EXC_INT),
        .BD_OFF   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    stage_rec_t        mdl [NS];
    bit                m_exl;
    bit                m_flushing;
    bit                e_take;
    bit                e_eret;
    bit                e_bd;
    logic [CODE_W-1:0] e_code;
    logic [PC_W-1:0]   e_epc;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NS*CODE_W-1:0] excAt(input int k, input logic [CODE_W-1:0] c);
        logic [NS*CODE_W-1:0] v;
        v = ALLNONE;
        v[k*CODE_W +: CODE_W] = c;
        return v;
    endfunction

    function automatic logic [CODE_W-1:0] mergedOf(input int k);
        if (mdl[k].code != NONE) return mdl[k].code;
        return bus.stage_exc[k*CODE_W +: CODE_W];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NS; k++) begin
            mdl[k].valid = 1'b0;
            mdl[k].pc    = '0;
            mdl[k].bd    = 1'b0;
            mdl[k].eret  = 1'b0;
            mdl[k].code  = NONE;
        end
        m_exl      = 1'b0;
        m_flushing = 1'b0;
    endtask

    // What the commit logic must produce given the model state and inputs.
    task automatic modelOutputs();
        int oldest;
        int victim;
        bit intr;
        bit sync;
        logic [CODE_W-1:0] mc;
        e_take = 0; e_eret = 0; e_bd = 0; e_code = '0; e_epc = '0;
        if (!m_flushing) begin
            oldest = -1;
            for (int k = 0; k < NS; k++) if (mdl[k].valid) oldest = k;
            mc     = mergedOf(C);
            intr   = bus.int_req && !m_exl && (oldest >= 0);
            sync   = mdl[C].valid && (mc != NONE);
            victim = C;
            if (intr) begin
                e_take = 1; e_code = EXC_INT; victim = oldest;
            end else if (sync) begin
                e_take = 1; e_code = mc;
            end
            if (e_take) begin
                e_bd  = mdl[victim].bd;
                e_epc = e_bd ? mdl[victim].pc - 32'd4 : mdl[victim].pc;
            end
            e_eret = mdl[C].valid && mdl[C].eret && (mc == NONE) && !intr;
        end
    endtask

    // Advance the model across one clock edge.
    task automatic modelUpdate();
        stage_rec_t nxt [NS];
        modelOutputs();
        if (m_flushing || e_take || e_eret) begin
            if (e_take)      m_exl = 1'b1;
            else if (e_eret) m_exl = 1'b0;
            m_flushing = e_take || e_eret;
            for (int k = 0; k < NS; k++) begin
                mdl[k].valid = 1'b0; mdl[k].pc = '0; mdl[k].bd = 1'b0;
                mdl[k].eret = 1'b0;  mdl[k].code = NONE;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                nxt[k] = mdl[k];
                if (bus.stall[k]) begin
                    nxt[k].code = mergedOf(k);
                end else if (k == 0) begin
                    nxt[0].valid = bus.ins_valid; nxt[0].pc = bus.ins_pc;
                    nxt[0].bd = bus.ins_bd; nxt[0].eret = bus.ins_eret;
                    nxt[0].code = NONE;
                end else if (bus.stall[k-1]) begin
                    nxt[k].valid = 1'b0; nxt[k].pc = '0; nxt[k].bd = 1'b0;
                    nxt[k].eret = 1'b0;  nxt[k].code = NONE;
                end else begin
                    nxt[k] = mdl[k-1];
                    nxt[k].code = mergedOf(k-1);
                end
            end
            for (int k = 0; k < NS; k++) mdl[k] = nxt[k];
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [PC_W-1:0] p, input logic b,
                                 input logic e, input logic [NS*CODE_W-1:0] x,
                                 input logic [NS-1:0] s, input logic ir);
        bus.ins_valid = v;
        bus.ins_pc    = p;
        bus.ins_bd    = b;
        bus.ins_eret  = e;
        bus.stage_exc = x;
        bus.stall     = s;
        bus.int_req   = ir;
    endtask

    // Compare every DUT output against the model, mid-cycle.
    task automatic checkOutput();
        logic [NS-1:0] sv;
        #2;
        modelOutputs();
        for (int k = 0; k < NS; k++) sv[k] = mdl[k].valid;
        checkEq("exc_take",    32'(bus.exc_take),    32'(e_take));
        checkEq("eret_take",   32'(bus.eret_take),   32'(e_eret));
        checkEq("epc_we",      32'(bus.epc_we),      32'(e_take && !m_exl));
        checkEq("flush_all",   32'(bus.flush_all),   32'(m_flushing));
        checkEq("exl",         32'(bus.exl),         32'(m_exl));
        checkEq("stage_valid", 32'(bus.stage_valid), 32'(sv));
        if (e_take) begin
            checkEq("exc_code", 32'(bus.exc_code), 32'(e_code));
            checkEq("exc_epc",  bus.exc_epc,       e_epc);
            checkEq("exc_bd",   32'(bus.exc_bd),   32'(e_bd));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic step();
        checkOutput();
        advance();
    endtask

    task automatic bubbleCycle();
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 0);
        step();
    endtask

    // Push an eret through an empty pipe and check it commits and flushes.
    task automatic doEret(input logic [PC_W-1:0] p);
        applyStimulus(1, p, 0, 1, ALLNONE, '0, 0);
        step();
        repeat (3) bubbleCycle();
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 0);
        checkOutput();
        checkEq("eret_lit_take", 32'(bus.eret_take), 32'd1);
        advance();
        checkOutput();
        checkEq("eret_lit_flush", 32'(bus.flush_all), 32'd1);
        checkEq("eret_lit_exl",   32'(bus.exl),       32'd0);
        advance();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 0);
        modelReset();
        @(negedge clk);
        checkOutput();
        checkEq("rst_stage_valid", 32'(bus.stage_valid), 32'd0);
        checkEq("rst_take",        32'(bus.exc_take),    32'd0);
        checkEq("rst_flush",       32'(bus.flush_all),   32'd0);
        checkEq("rst_exl",         32'(bus.exl),         32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Overflow detected in stage 1, taken at commit.
        applyStimulus(1, 32'h3000, 0, 0, ALLNONE, '0, 0); step();
        bubbleCycle();
        applyStimulus(0, '0, 0, 0, excAt(1, EXC_OV), '0, 0); step();
        bubbleCycle();
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 0);
        checkOutput();
        checkEq("ov_take", 32'(bus.exc_take), 32'd1);
        checkEq("ov_code", 32'(bus.exc_code), 32'd12);
        checkEq("ov_epc",  bus.exc_epc,       32'h3000);
        checkEq("ov_bd",   32'(bus.exc_bd),   32'd0);
        checkEq("ov_we",   32'(bus.epc_we),   32'd1);
        advance();
        checkOutput();
        checkEq("ov_flush", 32'(bus.flush_all),   32'd1);
        checkEq("ov_valid", 32'(bus.stage_valid), 32'd0);
        checkEq("ov_exl",   32'(bus.exl),         32'd1);
        advance();
        doEret(32'h5000);

        // Older detection (RI in stage 0) beats AdEL in stage 2.
        applyStimulus(1, 32'h3100, 0, 0, ALLNONE, '0, 0); step();
        applyStimulus(0, '0, 0, 0, excAt(0, EXC_RI), '0, 0); step();
        bubbleCycle();
        applyStimulus(0, '0, 0, 0, excAt(2, EXC_ADEL), '0, 0); step();
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 0);
        checkOutput();
        checkEq("ri_code", 32'(bus.exc_code), 32'd10);
        checkEq("ri_epc",  bus.exc_epc,       32'h3100);
        advance();
        bubbleCycle();
        doEret(32'h5100);

        // Delay-slot victim backs EPC off to the branch.
        applyStimulus(1, 32'h3008, 1, 0, ALLNONE, '0, 0); step();
        repeat (3) bubbleCycle();
        applyStimulus(0, '0, 0, 0, excAt(3, EXC_ADES), '0, 0);
        checkOutput();
        checkEq("bd_code", 32'(bus.exc_code), 32'd5);
        checkEq("bd_epc",  bus.exc_epc,       32'h3004);
        checkEq("bd_bd",   32'(bus.exc_bd),   32'd1);
        advance();
        bubbleCycle();

        // With exl=1, an eret carrying Ov at commit is a nested exception.
        applyStimulus(1, 32'h5200, 0, 1, ALLNONE, '0, 0); step();
        repeat (3) bubbleCycle();
        applyStimulus(0, '0, 0, 0, excAt(3, EXC_OV), '0, 0);
        checkOutput();
        checkEq("nest_take", 32'(bus.exc_take),  32'd1);
        checkEq("nest_eret", 32'(bus.eret_take), 32'd0);
        checkEq("nest_we",   32'(bus.epc_we),    32'd0);
        advance();
        bubbleCycle();
        checkEq("nest_exl", 32'(bus.exl), 32'd1);
        doEret(32'h5300);

        // Interrupt with only stage 1 valid, then held while exl=1.
        applyStimulus(1, 32'h4010, 0, 0, ALLNONE, '0, 0); step();
        bubbleCycle();
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 1);
        checkOutput();
        checkEq("int_take", 32'(bus.exc_take), 32'd1);
        checkEq("int_code", 32'(bus.exc_code), 32'd0);
        checkEq("int_epc",  bus.exc_epc,       32'h4010);
        checkEq("int_we",   32'(bus.epc_we),   32'd1);
        advance();
        step();
        applyStimulus(1, 32'h4100, 0, 0, ALLNONE, '0, 1); step();
        repeat (3) begin
            applyStimulus(0, '0, 0, 0, ALLNONE, '0, 1);
            checkOutput();
            checkEq("int_masked", 32'(bus.exc_take), 32'd0);
            advance();
        end
        bubbleCycle();
        doEret(32'h5400);

        // Stall stage 1 for two cycles, then interrupt to read its pc back.
        applyStimulus(1, 32'h6000, 0, 0, ALLNONE, '0, 0); step();
        bubbleCycle();
        applyStimulus(0, '0, 0, 0, ALLNONE, 4'b0010, 0); step();
        applyStimulus(0, '0, 0, 0, ALLNONE, 4'b0010, 0);
        checkOutput();
        checkEq("stall_valid", 32'(bus.stage_valid), 32'b0010);
        advance();
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 1);
        checkOutput();
        checkEq("stall_valid2", 32'(bus.stage_valid), 32'b0010);
        checkEq("stall_epc",    bus.exc_epc,          32'h6000);
        advance();

        // Reset asserted in the middle of the flush cycle.
        applyStimulus(0, '0, 0, 0, ALLNONE, '0, 0);
        checkOutput();
        checkEq("pre_rst_flush", 32'(bus.flush_all), 32'd1);
        #1 reset = 1'b1;
        #1;
        modelReset();
        checkEq("mid_rst_flush", 32'(bus.flush_all),   32'd0);
        checkEq("mid_rst_exl",   32'(bus.exl),         32'd0);
        checkEq("mid_rst_valid", 32'(bus.stage_valid), 32'd0);
        checkEq("mid_rst_take",  32'(bus.exc_take),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [NS*CODE_W-1:0] x;
            logic [NS-1:0]        s;
            logic [CODE_W-1:0]    pick [4];
            pick[0] = EXC_ADEL; pick[1] = EXC_ADES; pick[2] = EXC_RI; pick[3] = EXC_OV;
            x = ALLNONE;
            s = '0;
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(0, 11) == 0) x[k*CODE_W +: CODE_W] = pick[$urandom_range(0, 3)];
                s[k] = ($urandom_range(0, 7) == 0);
            end
            applyStimulus($urandom_range(0, 3) != 0, {$urandom_range(0, 32'hFFFF), 2'b00},
                          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          x, s, $urandom_range(0, 19) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_track_pipe.md
Name: exc_track_pipe

Overview:
- Parametrised exception-tracking pipeline that runs alongside the datapath.
- Carries valid, PC, delay-slot flag, eret flag and the first exception code of each in-flight instruction through NSTAGE stages, merging per-stage detector codes (older detection wins).
- At the commit stage it raises precise exceptions and interrupts, produces EPC/BD/code for CP0, drives the pipeline flush and tracks EXL.
- Bubbles are marked by explicit valid bits, never by PC==0.

Parameters:
NSTAGE, 4, number of tracked stages (>=2); stage 0 = entry, stage NSTAGE-1 = commit
PC_W, 32, PC width
CODE_W, 5, exception code width
NEXC, 5'h1F, "no exception" code
CODE_INT, 5'h00, interrupt code
BD_OFF, 4, EPC back-off applied to delay-slot victims

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ins_valid  in  1  instruction presented to stage 0
ins_pc  in  PC_W  PC of entering instruction
ins_bd  in  1  entering instruction sits in a branch delay slot
ins_eret  in  1  entering instruction is eret
stage_exc  in  NSTAGE*CODE_W  detector code for the instruction now in stage k (slice k); NEXC = none
stall  in  NSTAGE  stage k holds its contents
int_req  in  1  level interrupt request
exc_take  out  1  exception/interrupt taken this cycle
exc_code  out  CODE_W  code of taken event
exc_epc  out  PC_W  EPC value
exc_bd  out  1  Cause.BD value
epc_we  out  1  write EPC/BD (exc_take & !exl)
eret_take  out  1  eret committed this cycle
flush_all  out  1  registered flush of all datapath stages
exl  out  1  exception level
stage_valid  out  NSTAGE  per-stage valid, for debug/hazard use

Behaviour:
- Reset (async): all stage valids 0, codes NEXC, PC/bd/eret 0; exl 0; FSM in NORM; flush_all 0. With all stages invalid, exc_take and eret_take are 0.
- merged[k] = (code[k] != NEXC) ? code[k] : stage_exc[k]. The earliest-recorded code is never overwritten.
- Stage k update on clk edge, if !stall[k]:
  - k=0: loads ins_* with code NEXC (valid = ins_valid).
  - k>0: if stall[k-1], loads a bubble (valid 0, code NEXC); otherwise loads stage k-1 with code merged[k-1].
  - If stall[k], stage k holds, but its code still updates to merged[k].
- Victim selection:
  - Commit stage C = NSTAGE-1.
  - Sync exception: valid[C] & merged[C] != NEXC.
  - Interrupt: int_req & !exl & any valid stage. Victim = highest-index valid stage.
  - Interrupt has priority over a sync exception; code CODE_INT.
  - No valid stage: interrupt is deferred, nothing taken.
- Take (combinational, same cycle the victim is at its position, FSM in NORM):
  - exc_take = 1; exc_code = merged code, or CODE_INT for an interrupt.
  - exc_epc = victim.bd ? victim.pc - BD_OFF : victim.pc, modulo 2^PC_W. exc_bd = victim.bd.
  - epc_we = !exl. A nested exception keeps the old EPC but is still taken.
- eret: valid[C] & eret[C] & merged[C]==NEXC & no interrupt taken -> eret_take = 1.
- FSM:
  - NORM: exc_take or eret_take -> FLUSH at the next edge. On that edge all valids clear, codes go to NEXC, and stage 0 ignores ins_valid. exl <= 1 on exc_take, exl <= 0 on eret_take.
  - FLUSH: flush_all = 1 for exactly one cycle. exc_take and eret_take are forced 0. Stages stay cleared and the entry is ignored. Returns to NORM next edge.
  - Latency: event in cycle t -> flush_all and cleared valids in cycle t+1 -> entry accepted again in cycle t+2.
- Boundaries:
  - stall[C] does not block a take.
  - An exception and an eret at commit in the same cycle: the exception wins.
  - int_req while exl=1 is ignored.
  - reset during FLUSH returns to NORM immediately.

Decomposition:
- exc_pkg: code constants INT=0, AdEL=4, AdES=5, RI=10, Ov=12, NEXC=31; stage record typedef {valid, pc, bd, eret, code}; FSM state enum {NORM, FLUSH}.
- Sub-module exc_stage_reg: one stage register with stall/bubble/flush/merge, generate-instantiated NSTAGE times.
- The top level holds victim select, EPC math, the FSM and exl.

Test Plan:
- Ov at stage 1 for pc=0x3000, no stalls, NSTAGE=4 -> exc_take at commit two cycles later: code 12, epc 0x3000, bd 0, epc_we 1; next cycle flush_all=1, stage_valid=0000.
- RI at stage 0 and AdEL at stage 2 on the same instruction -> exc_code 10.
- Delay-slot instruction pc=0x3008, bd=1, AdES at commit -> exc_epc 0x3004, exc_bd 1.
- int_req with only stage 1 valid (pc=0x4010), commit bubble -> exc_take, code 0, epc 0x4010; int_req held while exl=1 -> no further take.
- eret reaches commit with exl=1 -> eret_take 1, flush next cycle, exl 0; an Ov at commit in the same cycle instead -> exc_take, eret_take 0.
- stall[1]=1 for 2 cycles -> stage 2 receives bubbles and stage 1 holds its pc; assert reset mid-FLUSH -> all outputs return to their reset values asynchronously.
